// File: rtl/intersection_controller.sv
// Two-way intersection light controller: fixed phase cycle timed by a down-counter,
// pedestrian requests that truncate the cross green, and an ERROR state for bad timing config.
module intersection_controller (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [17:0] timer_config,
    input  logic        ped_req_ns,
    input  logic        ped_req_ew,
    output logic [2:0]  light_ns,
    output logic [2:0]  light_ew,
    output logic        walk_ns,
    output logic        walk_ew,
    output logic        ped_ack_ns,
    output logic        ped_ack_ew,
    output logic        error_status
);

    typedef enum logic [2:0] {
        ALL_RED_A = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        ALL_RED_B = 3'd3,
        EW_GREEN  = 3'd4,
        EW_YELLOW = 3'd5,
        ERROR     = 3'd6
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [5:0] r_cnt;
    logic [5:0] w_next_cnt;
    logic       r_pend_ns;
    logic       r_pend_ew;
    logic [2:0] r_light_ns;
    logic [2:0] r_light_ew;
    logic       r_walk_ns;
    logic       r_walk_ew;
    logic       r_ack_ns;
    logic       r_ack_ew;
    logic       r_error;
    logic       w_cfg_ok;
    logic       w_truncate;
    logic       w_trans;
    logic       w_enter_ns;
    logic       w_enter_ew;

    function automatic logic cfg_valid(input logic [17:0] cfg);
        return (cfg[17:12] != 6'd0) && (cfg[11:6] != 6'd0) && (cfg[5:0] != 6'd0);
    endfunction

    function automatic state_t succ(input state_t s);
        case (s)
            ALL_RED_A: succ = NS_GREEN;
            NS_GREEN:  succ = NS_YELLOW;
            NS_YELLOW: succ = ALL_RED_B;
            ALL_RED_B: succ = EW_GREEN;
            EW_GREEN:  succ = EW_YELLOW;
            default:   succ = ALL_RED_A;
        endcase
    endfunction

    // Counter value loaded on phase entry: the phase's field minus one
    function automatic logic [5:0] load_val(input state_t s, input logic [17:0] cfg);
        case (s)
            NS_GREEN, EW_GREEN:   load_val = cfg[5:0] - 6'd1;
            NS_YELLOW, EW_YELLOW: load_val = cfg[11:6] - 6'd1;
            default:              load_val = cfg[17:12] - 6'd1;
        endcase
    endfunction

    function automatic logic [2:0] light_of(input state_t s, input state_t g, input state_t y);
        if (s == g) begin
            light_of = 3'b001;
        end else if (s == y) begin
            light_of = 3'b010;
        end else begin
            light_of = 3'b100;
        end
    endfunction

    // Next state and next counter value
    always_comb begin
        w_cfg_ok     = cfg_valid(timer_config);
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_truncate   = ((r_state == NS_GREEN) && r_pend_ew) ||
                       ((r_state == EW_GREEN) && r_pend_ns);
        if (!enable) begin
            w_next_state = r_state;
            w_next_cnt   = r_cnt;
        end else if (r_state == ERROR) begin
            if (w_cfg_ok) begin
                w_next_state = ALL_RED_A;
                w_next_cnt   = load_val(ALL_RED_A, timer_config);
            end else begin
                w_next_state = ERROR;
                w_next_cnt   = r_cnt;
            end
        end else if (r_cnt == 6'd0) begin
            if (w_cfg_ok) begin
                w_next_state = succ(r_state);
                w_next_cnt   = load_val(succ(r_state), timer_config);
            end else begin
                w_next_state = ERROR;
                w_next_cnt   = 6'd0;
            end
        end else if (w_truncate && (r_cnt > 6'd2)) begin
            // cross-direction pedestrian waiting: leave three more green cycles
            w_next_cnt = 6'd2;
        end else begin
            w_next_cnt = r_cnt - 6'd1;
        end
    end

    assign w_trans    = (w_next_state != r_state);
    assign w_enter_ns = w_trans && (w_next_state == NS_GREEN);
    assign w_enter_ew = w_trans && (w_next_state == EW_GREEN);

    // State, counter and light/error registers; lights decode the next state so they switch with it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ALL_RED_A;
            r_cnt      <= 6'd0;
            r_light_ns <= 3'b100;
            r_light_ew <= 3'b100;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_cnt      <= w_next_cnt;
            r_light_ns <= light_of(w_next_state, NS_GREEN, NS_YELLOW);
            r_light_ew <= light_of(w_next_state, EW_GREEN, EW_YELLOW);
            r_error    <= (w_next_state == ERROR);
        end
    end

    // Pedestrian pending latches, walk indications and acknowledge pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend_ns <= 1'b0;
            r_pend_ew <= 1'b0;
            r_walk_ns <= 1'b0;
            r_walk_ew <= 1'b0;
            r_ack_ns  <= 1'b0;
            r_ack_ew  <= 1'b0;
        end else begin
            r_pend_ns <= (w_enter_ns && r_pend_ns) ? 1'b0 : (r_pend_ns | ped_req_ns);
            r_pend_ew <= (w_enter_ew && r_pend_ew) ? 1'b0 : (r_pend_ew | ped_req_ew);
            r_ack_ns  <= w_enter_ns && r_pend_ns;
            r_ack_ew  <= w_enter_ew && r_pend_ew;
            if (w_trans) begin
                r_walk_ns <= w_enter_ns && r_pend_ns;
                r_walk_ew <= w_enter_ew && r_pend_ew;
            end else begin
                r_walk_ns <= r_walk_ns;
                r_walk_ew <= r_walk_ew;
            end
        end
    end

    assign light_ns     = r_light_ns;
    assign light_ew     = r_light_ew;
    assign walk_ns      = r_walk_ns;
    assign walk_ew      = r_walk_ew;
    assign ped_ack_ns   = r_ack_ns;
    assign ped_ack_ew   = r_ack_ew;
    assign error_status = r_error;

endmodule
